io_port_bank: RTL and testbench
===============================

Name: io_port_bank

Overview:
- Parametrised successor to the datapath's single-register in-port/out-port pair.
- Provides CHANNELS independent I/O channels. Each channel has an inbound FIFO (external producer -> CPU bus) and an outbound FIFO (CPU bus -> external consumer), both DEPTH deep.
- The CPU side is driven by the control unit's port-in/port-out strobes plus a channel select taken from the IR.
- The block raises stall when a strobe cannot complete, so the control unit holds its current step.

Parameters:
- DATA_W, 32, data width of the bus and FIFOs.
- CHANNELS, 2, number of I/O channels (1..8).
- DEPTH, 4, entries per FIFO; power of two, at least 2.
- SEL_W, 3, width of the channel select field.

Ports:
- clock  in  1  single system clock, rising edge.
- clear  in  1  asynchronous, active-high reset.
- sel  in  SEL_W  CPU channel select.
- bus_in  in  DATA_W  CPU bus value (BusMuxOut).
- out_wr  in  1  push bus_in into the outbound FIFO of channel sel.
- in_rd  in  1  pop the inbound FIFO of channel sel.
- bus_out  out  DATA_W  head of the inbound FIFO of channel sel; drives a bus-mux input.
- stall  out  1  the current strobe cannot complete this cycle.
- in_count  out  clog2(DEPTH+1)  occupancy of the inbound FIFO of channel sel.
- bad_sel  out  1  sticky: a strobe was issued with sel >= CHANNELS.
- ext_in_data  in  CHANNELS*DATA_W  producer data; channel c occupies bits [c*DATA_W +: DATA_W].
- ext_in_valid  in  CHANNELS  producer valid.
- ext_in_ready  out  CHANNELS  inbound FIFO not full.
- ext_out_data  out  CHANNELS*DATA_W  head of each outbound FIFO.
- ext_out_valid  out  CHANNELS  outbound FIFO not empty.
- ext_out_ready  in  CHANNELS  consumer ready.

Behaviour:
- Reset (clear=1, asynchronous, takes effect immediately):
  - All FIFO pointers and counts go to 0; bad_sel=0.
  - Outputs while in reset: ext_out_valid=0, ext_in_ready=all 1s, bus_out=0, in_count=0, stall=0, ext_out_data=0.
  - Clear mid-transfer discards all buffered words; no partial state survives.
- FIFO contents are not reset. Every output that exposes a head word is masked to 0 when its FIFO is empty.
- Handshakes:
  - External side uses valid/ready. A transfer occurs on a rising edge when valid && ready.
  - ext_in_ready = !in_full[c] and ext_out_valid = !out_empty[c]. Both are registered-state derived; there is no combinational valid->ready path.
- Latency:
  - A word accepted on ext_in at edge k is visible on bus_out (when selected) from cycle k+1.
  - A word written by out_wr at edge k is on ext_out_data with ext_out_valid=1 from cycle k+1.
  - There is no bypass through an empty FIFO.
- CPU side:
  - bus_out is combinational: the inbound head of channel sel, or 0 when that FIFO is empty or sel is invalid.
  - in_rd pops on the rising edge.
  - out_wr pushes bus_in on the rising edge.
- stall = (in_rd && in_empty[sel]) || (out_wr && out_full[sel]), evaluated on pre-edge state.
  - A stalled strobe changes no state. The control unit re-issues the strobe next cycle.
- Simultaneous events on one FIFO:
  - Push and pop in the same cycle when the FIFO is neither empty nor full: both occur, count unchanged.
  - When the FIFO is full, the push is refused (ready/stall based on pre-edge state) even if a pop occurs in the same cycle.
  - When the FIFO is empty, the pop is refused even if a push occurs in the same cycle.
- in_rd and out_wr may both be asserted in the same cycle; they act on different FIFOs of channel sel, independently.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. Count is a separate clog2(DEPTH+1)-bit counter in 0..DEPTH.
- Invalid select (sel >= CHANNELS):
  - Strobes are ignored and stall=0.
  - bad_sel sets on the edge and holds until clear.
  - bus_out=0 and in_count=0.
- No data width conversion; all words are DATA_W bits.

Decomposition:
- Package io_port_pkg:
  - default DATA_W and CHANNELS;
  - a clog2-based count-width function;
  - local constants PTR_W and CNT_W.
- Sub-module io_fifo:
  - synchronous FIFO with push, pop, full, empty, count and show-ahead head;
  - instantiated 2*CHANNELS times.
- The top level holds the sel decode, output muxes, stall logic and bad_sel.

Test Plan:
- Reset, then idle: bus_out=0, ext_in_ready=2'b11, ext_out_valid=2'b00, stall=0, in_count=0.
- Outbound write: sel=1, out_wr with bus_in=32'hDEADBEEF, ext_out_ready=0.
  - Next cycle: ext_out_valid[1]=1 and ext_out_data[63:32]=DEADBEEF.
  - Then ext_out_ready[1]=1 for one cycle: ext_out_valid[1]=0.
- Inbound fill: push 5 words 1..5 on channel 0 with DEPTH=4.
  - ext_in_ready[0]=0 after 4 accepts and the 5th is held.
  - sel=0, in_rd: bus_out=1, then 2 after the edge; the 5th word is accepted on the next edge.
- Stall on empty in-FIFO: in_rd on empty channel 0 -> stall=1, in_count stays 0, no pointer movement.
- Stall on full out-FIFO: out_wr with out FIFO full and ext_out_ready=1 in the same cycle.
  - stall=1, the pop occurs, and the retried write succeeds the next cycle.
- Error, wrap and reset:
  - sel=5 with out_wr -> bad_sel=1, no FIFO change.
  - 10 push/pop pairs on one FIFO wrap the pointers with data order preserved.
  - clear pulsed mid-stream -> all counts 0 immediately, bad_sel=0.

Source files
------------

// File: rtl/io_port_pkg.sv
// rtl/io_port_pkg.sv - shared defaults and width helpers for the I/O port bank
package io_port_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_CHANNELS = 2;
    localparam int DEF_DEPTH    = 4;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int PTR_W = $clog2(DEF_DEPTH);
    localparam int CNT_W = cnt_width(DEF_DEPTH);

endpackage

// File: rtl/io_fifo.sv
// rtl/io_fifo.sv - show-ahead synchronous FIFO with separate occupancy counter
module io_fifo
    import io_port_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                         clock,
    input  logic                         clear,
    input  logic                         push,
    input  logic                         pop,
    input  logic [DATA_W-1:0]            din,
    output logic [DATA_W-1:0]            head,
    output logic                         full,
    output logic [cnt_width(DEPTH)-1:0]  count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              empty;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Storage is never cleared, so the head is masked whenever nothing valid is held.
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_port_bank.sv
// rtl/io_port_bank.sv - multi-channel inbound/outbound FIFO bank on the CPU bus
module io_port_bank
    import io_port_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int SEL_W    = 3
) (
    input  logic                         clock,
    input  logic                         clear,
    input  logic [SEL_W-1:0]             sel,
    input  logic [DATA_W-1:0]            bus_in,
    input  logic                         out_wr,
    input  logic                         in_rd,
    output logic [DATA_W-1:0]            bus_out,
    output logic                         stall,
    output logic [cnt_width(DEPTH)-1:0]  in_count,
    output logic                         bad_sel,
    input  logic [CHANNELS*DATA_W-1:0]   ext_in_data,
    input  logic [CHANNELS-1:0]          ext_in_valid,
    output logic [CHANNELS-1:0]          ext_in_ready,
    output logic [CHANNELS*DATA_W-1:0]   ext_out_data,
    output logic [CHANNELS-1:0]          ext_out_valid,
    input  logic [CHANNELS-1:0]          ext_out_ready
);

    localparam int CW = cnt_width(DEPTH);
    localparam logic [SEL_W:0] NCH = (SEL_W + 1)'(CHANNELS);

    logic                sel_ok;
    logic [CHANNELS-1:0] ch_hit;
    logic [CHANNELS-1:0] in_full;
    logic [CHANNELS-1:0] in_empty;
    logic [CHANNELS-1:0] out_full;
    logic [CHANNELS-1:0] out_empty;
    logic [DATA_W-1:0]   in_head [CHANNELS];
    logic [CW-1:0]       in_cnt  [CHANNELS];
    logic [CW-1:0]       out_cnt [CHANNELS];

    assign sel_ok = ({1'b0, sel} < NCH);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        assign ch_hit[c]    = sel_ok && (sel == SEL_W'(c));
        assign in_empty[c]  = (in_cnt[c] == '0);
        assign out_empty[c] = (out_cnt[c] == '0);

        io_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_in (
            .clock (clock),
            .clear (clear),
            .push  (ext_in_valid[c]),
            .pop   (in_rd && ch_hit[c]),
            .din   (ext_in_data[c*DATA_W +: DATA_W]),
            .head  (in_head[c]),
            .full  (in_full[c]),
            .count (in_cnt[c])
        );

        io_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_out (
            .clock (clock),
            .clear (clear),
            .push  (out_wr && ch_hit[c]),
            .pop   (ext_out_ready[c]),
            .din   (bus_in),
            .head  (ext_out_data[c*DATA_W +: DATA_W]),
            .full  (out_full[c]),
            .count (out_cnt[c])
        );
    end

    assign ext_in_ready  = ~in_full;
    assign ext_out_valid = ~out_empty;

    always_comb begin
        bus_out  = '0;
        in_count = '0;
        stall    = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (ch_hit[c]) begin
                bus_out  = in_head[c];
                in_count = in_cnt[c];
                // Counts read zero during clear; keep the strobe from looking stalled then.
                stall    = !clear && ((in_rd && in_empty[c]) || (out_wr && out_full[c]));
            end
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            bad_sel <= 1'b0;
        end else if ((in_rd || out_wr) && !sel_ok) begin
            bad_sel <= 1'b1;
        end
    end

endmodule

// File: tb/tb_io_port_bank.sv
// tb/tb_io_port_bank.sv - directed and randomized checks against a queue model
module tb_io_port_bank;

    localparam int DATA_W   = 32;
    localparam int CHANNELS = 2;
    localparam int DEPTH    = 4;
    localparam int SEL_W    = 3;

    logic                       clock = 1'b0;
    logic                       clear;
    logic [SEL_W-1:0]           sel;
    logic [DATA_W-1:0]          bus_in;
    logic                       out_wr;
    logic                       in_rd;
    logic [DATA_W-1:0]          bus_out;
    logic                       stall;
    logic [2:0]                 in_count;
    logic                       bad_sel;
    logic [CHANNELS*DATA_W-1:0] ext_in_data;
    logic [CHANNELS-1:0]        ext_in_valid;
    logic [CHANNELS-1:0]        ext_in_ready;
    logic [CHANNELS*DATA_W-1:0] ext_out_data;
    logic [CHANNELS-1:0]        ext_out_valid;
    logic [CHANNELS-1:0]        ext_out_ready;

    io_port_bank #(.DATA_W(DATA_W), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .SEL_W(SEL_W)) dut (
        .clock         (clock),
        .clear         (clear),
        .sel           (sel),
        .bus_in        (bus_in),
        .out_wr        (out_wr),
        .in_rd         (in_rd),
        .bus_out       (bus_out),
        .stall         (stall),
        .in_count      (in_count),
        .bad_sel       (bad_sel),
        .ext_in_data   (ext_in_data),
        .ext_in_valid  (ext_in_valid),
        .ext_in_ready  (ext_in_ready),
        .ext_out_data  (ext_out_data),
        .ext_out_valid (ext_out_valid),
        .ext_out_ready (ext_out_ready)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [31:0] inq  [CHANNELS][$];
    logic [31:0] outq [CHANNELS][$];
    bit          exp_bad = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int          s;
        bit          ok;
        logic [31:0] e_bus;
        logic [2:0]  e_cnt;
        bit          e_stall;
        logic [1:0]  e_ready;
        logic [1:0]  e_valid;
        logic [63:0] e_odata;
        s       = int'(sel);
        ok      = (s < CHANNELS);
        e_bus   = '0;
        e_cnt   = '0;
        e_stall = 1'b0;
        if (ok) begin
            if (inq[s].size() > 0) e_bus = inq[s][0];
            e_cnt = 3'(inq[s].size());
            e_stall = !clear && ((in_rd && inq[s].size() == 0) ||
                                 (out_wr && outq[s].size() == DEPTH));
        end
        e_odata = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            e_ready[c] = (inq[c].size() < DEPTH);
            e_valid[c] = (outq[c].size() > 0);
            if (outq[c].size() > 0) e_odata[c*32 +: 32] = outq[c][0];
        end
        check("bus_out", 64'(bus_out), 64'(e_bus));
        check("in_count", 64'(in_count), 64'(e_cnt));
        check("stall", 64'(stall), 64'(e_stall));
        check("ext_in_ready", 64'(ext_in_ready), 64'(e_ready));
        check("ext_out_valid", 64'(ext_out_valid), 64'(e_valid));
        check("ext_out_data", ext_out_data, e_odata);
        check("bad_sel", 64'(bad_sel), 64'(exp_bad));
    endtask

    task automatic model_update();
        int s;
        bit ok;
        int ni;
        int no;
        s  = int'(sel);
        ok = (s < CHANNELS);
        for (int c = 0; c < CHANNELS; c++) begin
            ni = inq[c].size();
            no = outq[c].size();
            if (in_rd && ok && s == c && ni > 0) void'(inq[c].pop_front());
            if (ext_in_valid[c] && ni < DEPTH) inq[c].push_back(ext_in_data[c*32 +: 32]);
            if (ext_out_ready[c] && no > 0) void'(outq[c].pop_front());
            if (out_wr && ok && s == c && no < DEPTH) outq[c].push_back(bus_in);
        end
        if ((in_rd || out_wr) && !ok) exp_bad = 1'b1;
    endtask

    task automatic tick();
        #1;
        check_outputs();
        model_update();
        @(posedge clock);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        #1;
        for (int c = 0; c < CHANNELS; c++) begin
            inq[c].delete();
            outq[c].delete();
        end
        exp_bad = 1'b0;
        check_outputs();
        check("clear_in_count", 64'(in_count), 64'd0);
        check("clear_bad_sel", 64'(bad_sel), 64'd0);
        @(posedge clock);
        #1;
        clear = 1'b0;
    endtask

    initial begin
        clear         = 1'b1;
        sel           = '0;
        bus_in        = '0;
        out_wr        = 1'b0;
        in_rd         = 1'b0;
        ext_in_data   = '0;
        ext_in_valid  = '0;
        ext_out_ready = '0;
        repeat (2) @(posedge clock);
        #1;
        check_outputs();
        clear = 1'b0;
        tick();
        tick();
        check("idle_ready", 64'(ext_in_ready), 64'b11);
        check("idle_valid", 64'(ext_out_valid), 64'b00);

        // Outbound write on channel 1, then drain it.
        sel = 3'd1; out_wr = 1'b1; bus_in = 32'hDEADBEEF;
        tick();
        out_wr = 1'b0;
        check("ob_valid1", 64'(ext_out_valid[1]), 64'd1);
        check("ob_data1", 64'(ext_out_data[63:32]), 64'hDEADBEEF);
        tick();
        ext_out_ready = 2'b10;
        tick();
        ext_out_ready = 2'b00;
        check("ob_drained", 64'(ext_out_valid[1]), 64'd0);
        tick();

        // Inbound fill past capacity on channel 0.
        sel = 3'd0; ext_in_valid = 2'b01;
        for (int w = 1; w <= 4; w++) begin
            ext_in_data[31:0] = 32'(w);
            tick();
        end
        ext_in_data[31:0] = 32'd5;
        #1;
        check("fill_ready0", 64'(ext_in_ready[0]), 64'd0);
        check("fill_count", 64'(in_count), 64'd4);
        in_rd = 1'b1;
        #1;
        check("fill_head1", 64'(bus_out), 64'd1);
        tick();
        in_rd = 1'b0;
        #1;
        check("fill_head2", 64'(bus_out), 64'd2);
        tick();
        ext_in_valid = 2'b00;
        #1;
        check("fill_fifth", 64'(in_count), 64'd4);

        // Drain, then read an empty inbound FIFO.
        in_rd = 1'b1;
        repeat (4) tick();
        #1;
        check("empty_stall", 64'(stall), 64'd1);
        tick();
        in_rd = 1'b0;
        check("empty_count", 64'(in_count), 64'd0);

        // Fill the outbound FIFO, then write while the consumer pops.
        sel = 3'd0; out_wr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus_in = $urandom;
            tick();
        end
        bus_in = 32'hA5A50005; ext_out_ready = 2'b01;
        #1;
        check("full_stall", 64'(stall), 64'd1);
        tick();
        ext_out_ready = 2'b00;
        #1;
        check("retry_stall", 64'(stall), 64'd0);
        tick();
        out_wr = 1'b0;
        ext_out_ready = 2'b01;
        repeat (5) tick();
        ext_out_ready = 2'b00;

        // Invalid channel select.
        sel = 3'd5; out_wr = 1'b1; bus_in = 32'h12345678;
        tick();
        out_wr = 1'b0;
        check("bad_sel_set", 64'(bad_sel), 64'd1);
        check("bad_sel_nochange", 64'(ext_out_valid), 64'd0);
        tick();

        // Pointer wrap with simultaneous push/pop on channel 1 inbound.
        sel = 3'd1; ext_in_valid = 2'b10; ext_in_data[63:32] = $urandom;
        tick();
        in_rd = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ext_in_data[63:32] = $urandom;
            tick();
        end
        ext_in_valid = 2'b00;
        tick();
        in_rd = 1'b0;
        check("wrap_count", 64'(in_count), 64'd0);

        // Randomized traffic with a clear in the middle.
        for (int i = 0; i < 400; i++) begin
            sel = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(2, 7));
            in_rd         = 1'($urandom);
            out_wr        = 1'($urandom);
            bus_in        = $urandom;
            ext_in_valid  = 2'($urandom);
            ext_out_ready = 2'($urandom);
            ext_in_data   = {$urandom, $urandom};
            if (i == 200) do_clear();
            tick();
        end
        in_rd = 1'b0; out_wr = 1'b0; ext_in_valid = '0; ext_out_ready = '0;
        do_clear();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
